// File: rtl/psum_requant_drain.sv
// Snapshots a tile of MAC partial sums, requantizes them to int8 (round, ReLU, saturate)
// and streams the tile out one row per valid/ready beat.
module psum_requant_drain #(
    parameter int unsigned NUM_ROWS = 16,
    parameter int unsigned NUM_COLS = 16,
    parameter int unsigned ACC_W    = 24,
    parameter int unsigned OUT_W    = 8,
    localparam int unsigned ROW_W   = $clog2(NUM_ROWS)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                tile_done,
    input  logic [NUM_ROWS*NUM_COLS*ACC_W-1:0] latch_array_in,
    input  logic [4:0]                          shift_amt,
    input  logic                                relu_en,
    input  logic                                out_ready,
    output logic                                out_valid,
    output logic [NUM_COLS*OUT_W-1:0]           out_data,
    output logic [ROW_W-1:0]                    out_row,
    output logic                                out_last,
    output logic [NUM_COLS-1:0]                 out_sat,
    output logic                                busy,
    output logic                                tile_overrun
);

    localparam int QMAX = 2 ** (OUT_W - 1) - 1;
    localparam int QMIN = -(2 ** (OUT_W - 1));
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);
    localparam logic [4:0] MAX_SHIFT = 5'(ACC_W - 1);

    typedef enum logic [1:0] {StIdle, StPrep, StDrain} state_e;

    state_e                                     state_q;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0][ACC_W-1:0] cap_q;
    logic [4:0]                                 shift_q;
    logic                                       relu_q;
    logic                                       overrun_q;

    logic [4:0]                 s_eff;
    logic [ROW_W-1:0]           q_row;
    logic [NUM_COLS*OUT_W-1:0]  q_data;
    logic [NUM_COLS-1:0]        q_sat;

    // Returns {sat, int8}; rounding adds half an LSB so ties go toward +inf.
    function automatic logic [OUT_W:0] quant_lane(input logic [ACC_W-1:0] v,
                                                  input logic [4:0]       s,
                                                  input logic             relu);
        logic signed [ACC_W:0] rnd;
        logic signed [ACC_W:0] sum;
        logic signed [ACC_W:0] shifted;
        rnd = '0;
        if (s != 5'd0) rnd[s - 5'd1] = 1'b1;
        sum     = $signed({v[ACC_W-1], v}) + rnd;
        shifted = sum >>> s;
        if (relu && shifted[ACC_W]) shifted = '0;
        if (int'(shifted) > QMAX) return {1'b1, OUT_W'(QMAX)};
        if (int'(shifted) < QMIN) return {1'b1, OUT_W'(QMIN)};
        return {1'b0, shifted[OUT_W-1:0]};
    endfunction

    // One shared quantizer: row 0 while in PREP, otherwise the row after the current beat.
    always_comb begin
        s_eff  = (shift_q > MAX_SHIFT) ? MAX_SHIFT : shift_q;
        q_row  = (state_q == StPrep) ? '0 : out_row + ROW_W'(1);
        q_data = '0;
        q_sat  = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            {q_sat[c], q_data[c*OUT_W +: OUT_W]} = quant_lane(cap_q[q_row][c], s_eff, relu_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cap_q     <= '0;
            shift_q   <= '0;
            relu_q    <= 1'b0;
            overrun_q <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_last  <= 1'b0;
            out_sat   <= '0;
        end else begin
            if (tile_done && state_q != StIdle) overrun_q <= 1'b1;
            case (state_q)
                StIdle: begin
                    if (tile_done) begin
                        cap_q   <= latch_array_in;
                        shift_q <= shift_amt;
                        relu_q  <= relu_en;
                        state_q <= StPrep;
                    end
                end
                StPrep: begin
                    out_data  <= q_data;
                    out_sat   <= q_sat;
                    out_row   <= '0;
                    out_last  <= (NUM_ROWS == 1);
                    out_valid <= 1'b1;
                    state_q   <= StDrain;
                end
                StDrain: begin
                    if (out_valid && out_ready) begin
                        if (out_row == LAST_ROW) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_row   <= '0;
                            state_q   <= StIdle;
                        end else begin
                            out_row  <= q_row;
                            out_data <= q_data;
                            out_sat  <= q_sat;
                            out_last <= (q_row == LAST_ROW);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy         = (state_q != StIdle);
    assign tile_overrun = overrun_q;

endmodule
